block_dispatcher: RTL
=====================

# block_dispatcher

Parametrised kernel-launch dispatcher sitting between the device control register and the compute-core array, replacing the fixed 8-bit, all-cores-at-once dispatcher. It splits a kernel's thread count into blocks of THREADS_PER_BLOCK, issues blocks one per cycle to free, enabled cores using a rotating priority, and reissues blocks as cores finish. It also adds a per-launch core-enable mask, abort, and error reporting. Kernel `done` is raised once every block has completed.

## Interface
- NUM_CORES, 2, number of compute cores served
- THREADS_PER_BLOCK, 4, threads per block; power of two ≥ 1
- THREAD_COUNT_BITS, 16, width of kernel thread count
- BLOCK_ID_BITS, 8, width of block id handed to a core
- Derived, TC_W = $clog2(THREADS_PER_BLOCK)+1, width of per-core thread count
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low; low at a rising edge resets all state
- start  in  1  launch request; sampled only in IDLE or DONE
- abort  in  1  stop the running kernel
- thread_count  in  THREAD_COUNT_BITS  kernel thread count; captured with start
- core_enable  in  NUM_CORES  cores usable this launch; captured with start
- core_done  in  NUM_CORES  per-core block completion, level
- core_reset  out  NUM_CORES  per-core reset pulse, one cycle
- core_start  out  NUM_CORES  per-core start, held until done
- core_block_id  out  NUM_CORES×BLOCK_ID_BITS  packed, core c at [c]
- core_thread_count  out  NUM_CORES×TC_W  packed, threads in core c's block
- busy  out  1  kernel in flight
- done  out  1  kernel finished; held high in DONE
- error  out  1  launch rejected; valid while done is high
- aborted  out  1  kernel ended by abort; valid while done is high

## Operation
- Top FSM: IDLE → RUN → DONE; abort in RUN → DRAIN → DONE; start in DONE → RUN, which clears done, error and aborted.
- On start:
  - latch thread_count and core_enable;
  - total_blocks = ceil(thread_count / THREADS_PER_BLOCK), computed with a shift and a round-up on nonzero low bits;
  - clear next_block and completed.
- Reject rules, in priority order. A rejected launch goes straight to DONE with no dispatch.
  - thread_count == 0 → DONE, error = 0.
  - core_enable == 0, or total_blocks > 2^BLOCK_ID_BITS → DONE, error = 1.
- Per-core states: FREE, RST, RUN.
- In RUN, each cycle with next_block < total_blocks:
  - select the first core c with FREE and enabled, searching round-robin from rr_ptr;
  - drive core_reset[c] = 1, core_block_id[c] = next_block, core_thread_count[c] = min(THREADS_PER_BLOCK, thread_count − next_block·THREADS_PER_BLOCK);
  - increment next_block; set rr_ptr = c+1 mod NUM_CORES; core c → RST.
- RST → RUN in the following cycle; core_start[c] = 1 while in RUN.
- core_done[c] high in RUN → core_start[c] low next cycle, completed += 1, core c → FREE. A freed core can be reselected in that same cycle.
- completed == total_blocks → DONE.
- DRAIN: no new dispatch; core_reset pulses for one cycle on every core in RST or RUN, then all cores go FREE; DONE with aborted = 1.
- core_block_id and core_thread_count hold their value until the next dispatch to that core.

## Timing
- Reset values: all outputs 0; FSM IDLE; rr_ptr 0; all cores FREE.
- start at cycle T (accepted) → busy = 1 at T+1, first core_reset at T+1, core_start at T+2. Blocks go out one per cycle: core k resets at T+1+k.
- core_done at cycle D → core_start low at D+1. If blocks remain, the same core may reset at D+1.
- Final completion at D → done = 1 and busy = 0 at D+1.
- Rejected launch: done = 1 at T+1, no core_reset.
- Simultaneous events:
  - abort and final core_done in the same cycle: abort wins, aborted = 1;
  - start together with abort: abort is ignored outside RUN;
  - start outside IDLE/DONE is ignored.
- core_done on a core not in RUN is ignored.
- reset low mid-kernel → all outputs 0 at the next edge; no core_reset pulse is generated.

## Structure
- Package block_dispatch_pkg holds:
  - enum types for top-FSM and per-core states;
  - helper function ceil_div_pow2;
  - TC_W as a localparam function.
- Sub-module rr_arbiter (NUM_CORES request vector, pointer in → one-hot grant plus index) is instantiated once for free-core selection.
- Everything else lives in block_dispatcher.

## Test plan
- TPB=4, 2 cores, thread_count=10, enable=2'b11 → blocks 0,1,2 with counts 4,4,2; block 2 goes to the first core to finish; done 1 cycle after the 3rd core_done.
- thread_count=0 → done at T+1, error=0, no core_reset.
- enable=2'b10, thread_count=8 → both blocks go to core 1 only; core_start[0] never asserts.
- BLOCK_ID_BITS=2, thread_count=17, TPB=4 (5 blocks > 4) → done at T+1 with error=1.
- abort while 2 cores are in RUN → one-cycle core_reset on both cores next cycle, then done=1, aborted=1, and further core_done pulses are ignored.
- reset low for one cycle mid-RUN → every output 0 at the next edge; a new start then launches cleanly from block 0.

Source files
------------

// File: rtl/block_dispatch_pkg.sv
// Shared types and helpers for the kernel block dispatcher.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package block_dispatch_pkg;

  // Top-level kernel FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } top_state_e;

  // Per-core dispatch states
  typedef enum logic [1:0] {
    CORE_FREE = 2'd0,
    CORE_RST  = 2'd1,
    CORE_RUN  = 2'd2
  } core_state_e;

  // Width of a per-core thread count: must hold THREADS_PER_BLOCK itself
  function automatic int tc_w(input int tpb);
    return $clog2(tpb) + 1;
  endfunction

  // ceil(n / 2^sh): shift, then round up when any discarded low bit is set
  function automatic logic [31:0] ceil_div_pow2(input logic [31:0] n,
                                               input int unsigned sh);
    logic [31:0] mask;
    mask = (32'd1 << sh) - 32'd1;
    return (n >> sh) + {31'd0, |(n & mask)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: none; vld_o low when no request is set.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan N positions starting at the pointer; the first hit wins
  always_comb begin
    int unsigned c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (32'(ptr_i) + 32'(i)) % N;
      if (!vld_o && req_i[c[IDX_W-1:0]]) begin
        vld_o                 = 1'b1;
        gnt_o[c[IDX_W-1:0]]   = 1'b1;
        idx_o                 = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel into blocks and issues them one per cycle to free enabled cores.
// Latency: start -> first core_reset 1 cycle; last core_done -> done 1 cycle.
// Backpressure: blocks wait for a free enabled core; start ignored unless IDLE/DONE.
module block_dispatcher
  import block_dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 16,
  parameter int BLOCK_ID_BITS     = 8,
  localparam int TC_W             = tc_w(THREADS_PER_BLOCK)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,   // synchronous, active-low
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [THREAD_COUNT_BITS-1:0]       thread_count_i,
  input  logic [NUM_CORES-1:0]               core_enable_i,
  input  logic [NUM_CORES-1:0]               core_done_i,
  output logic [NUM_CORES-1:0]               core_reset_o,
  output logic [NUM_CORES-1:0]               core_start_o,
  output logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id_o,
  output logic [NUM_CORES*TC_W-1:0]          core_thread_count_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic                               aborted_o
);

  localparam int          IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned LOG2_TPB   = $clog2(THREADS_PER_BLOCK);
  localparam logic [32:0] MAX_BLOCKS = 33'd1 << BLOCK_ID_BITS;

  top_state_e                   state_q, state_d;
  core_state_e                  core_st_q [NUM_CORES];
  core_state_e                  core_st_d [NUM_CORES];
  logic [THREAD_COUNT_BITS-1:0] tc_q, tc_d;
  logic [NUM_CORES-1:0]         en_q, en_d;
  logic [31:0]                  total_q, total_d;
  logic [31:0]                  next_q, next_d;
  logic [31:0]                  completed_q, completed_d;
  logic [IDX_W-1:0]             rr_q, rr_d;
  logic [BLOCK_ID_BITS-1:0]     bid_q [NUM_CORES];
  logic [BLOCK_ID_BITS-1:0]     bid_d [NUM_CORES];
  logic [TC_W-1:0]              tcnt_q [NUM_CORES];
  logic [TC_W-1:0]              tcnt_d [NUM_CORES];
  logic                         error_q, error_d;
  logic                         aborted_q, aborted_d;

  // Launch decode works on the live inputs so block 0 goes out on the start edge
  logic                         launch, launch_zero, launch_err, launch_go;
  logic [31:0]                  launch_total;
  logic                         running, can_dispatch, dispatch;
  logic [THREAD_COUNT_BITS-1:0] eff_tc;
  logic [NUM_CORES-1:0]         eff_en;
  logic [31:0]                  eff_total, eff_next;
  logic [31:0]                  rem;
  logic [NUM_CORES-1:0]         core_fin, req, gnt;
  logic [IDX_W-1:0]             gnt_idx;
  logic                         gnt_vld;

  // Launch qualification and the parameters the dispatcher acts on this cycle
  always_comb begin
    launch       = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    launch_total = ceil_div_pow2(32'(thread_count_i), LOG2_TPB);
    launch_zero  = (thread_count_i == '0);
    launch_err   = (core_enable_i == '0) || ({1'b0, launch_total} > MAX_BLOCKS);
    launch_go    = launch && !launch_zero && !launch_err;
    running      = (state_q == ST_RUN) && !abort_i;
    can_dispatch = launch_go || running;
    eff_tc       = launch_go ? thread_count_i : tc_q;
    eff_en       = launch_go ? core_enable_i  : en_q;
    eff_total    = launch_go ? launch_total   : total_q;
    eff_next     = launch_go ? 32'd0          : next_q;
    rem          = 32'(eff_tc) - (eff_next << LOG2_TPB);
    for (int c = 0; c < NUM_CORES; c++) begin
      core_fin[c] = running && (core_st_q[c] == CORE_RUN) && core_done_i[c];
      req[c]      = can_dispatch && (eff_next < eff_total) && eff_en[c] &&
                    ((core_st_q[c] == CORE_FREE) || core_fin[c]);
    end
  end

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_free_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign dispatch = gnt_vld;

  // Next-state: top FSM, per-core FSMs, counters, and the dispatch write
  always_comb begin
    state_d     = state_q;
    tc_d        = tc_q;
    en_d        = en_q;
    total_d     = total_q;
    next_d      = next_q;
    completed_d = completed_q;
    rr_d        = rr_q;
    error_d     = error_q;
    aborted_d   = aborted_q;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_st_d[c] = core_st_q[c];
      bid_d[c]     = bid_q[c];
      tcnt_d[c]    = tcnt_q[c];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          error_d     = 1'b0;
          aborted_d   = 1'b0;
          tc_d        = thread_count_i;
          en_d        = core_enable_i;
          total_d     = launch_total;
          next_d      = 32'd0;
          completed_d = 32'd0;
          if (launch_zero) begin
            state_d = ST_DONE;
          end else if (launch_err) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort freezes the cores so DRAIN can see who needs a reset pulse
        if (abort_i) begin
          state_d = ST_DRAIN;
        end else begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if (core_st_q[c] == CORE_RST) begin
              core_st_d[c] = CORE_RUN;
            end
            if (core_fin[c]) begin
              core_st_d[c] = CORE_FREE;
              completed_d  = completed_d + 32'd1;
            end
          end
          if (completed_d == total_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        for (int c = 0; c < NUM_CORES; c++) begin
          core_st_d[c] = CORE_FREE;
        end
        state_d   = ST_DONE;
        aborted_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A freed core may be reselected on the same edge, so this overrides FREE
    if (dispatch) begin
      core_st_d[gnt_idx] = CORE_RST;
      bid_d[gnt_idx]     = eff_next[BLOCK_ID_BITS-1:0];
      tcnt_d[gnt_idx]    = (rem >= 32'(THREADS_PER_BLOCK)) ?
                           TC_W'(THREADS_PER_BLOCK) : rem[TC_W-1:0];
      next_d             = eff_next + 32'd1;
      rr_d               = (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      tc_q        <= '0;
      en_q        <= '0;
      total_q     <= '0;
      next_q      <= '0;
      completed_q <= '0;
      rr_q        <= '0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
      for (int c = 0; c < NUM_CORES; c++) begin
        core_st_q[c] <= CORE_FREE;
        bid_q[c]     <= '0;
        tcnt_q[c]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      en_q        <= en_d;
      total_q     <= total_d;
      next_q      <= next_d;
      completed_q <= completed_d;
      rr_q        <= rr_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
      for (int c = 0; c < NUM_CORES; c++) begin
        core_st_q[c] <= core_st_d[c];
        bid_q[c]     <= bid_d[c];
        tcnt_q[c]    <= tcnt_d[c];
      end
    end
  end

  // Output decode from registered state; DRAIN pulses reset on every busy core
  always_comb begin
    core_reset_o        = '0;
    core_start_o        = '0;
    core_block_id_o     = '0;
    core_thread_count_o = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_reset_o[c] = (core_st_q[c] == CORE_RST) ||
                        ((state_q == ST_DRAIN) && (core_st_q[c] == CORE_RUN));
      core_start_o[c] = (core_st_q[c] == CORE_RUN) && (state_q != ST_DRAIN);
      core_block_id_o[c*BLOCK_ID_BITS +: BLOCK_ID_BITS] = bid_q[c];
      core_thread_count_o[c*TC_W +: TC_W]               = tcnt_q[c];
    end
    busy_o    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done_o    = (state_q == ST_DONE);
    error_o   = error_q;
    aborted_o = aborted_q;
  end

endmodule
